mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
Multi-cycle control FSM that sequences the MIPS datapath: PC, instruction memory, decoder, RegisterBlock, ALU and data memory. It consumes the decoded opcode/funct, ALU zero flag and a memory-ready handshake. It drives every write enable and mux select, so one instruction completes over 3-5 cycles. It replaces free-running per-negedge PC increment with controlled pc_write.

Parameters:
MEM_WAIT_MAX, 16, max consecutive cycles waiting on mem_ready in FETCH or MEM before bus_error; legal range 1..31
WAIT_W, 5, width of wait counter; must hold MEM_WAIT_MAX

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
opcode  input  6  decoded instr[31:26]
funct  input  6  decoded instr[5:0]
alu_zero  input  1  ALU result == 0
mem_ready  input  1  memory access completes this cycle
pc_write  output  1  load PC this edge
pc_src  output  2  00 PC+1, 01 branch target (ALUOut), 10 jump {PC[31:26],addr}
ir_write  output  1  latch fetched instruction
mem_read  output  1  memory read request
mem_write  output  1  memory write request
iord  output  1  0 instr address (PC), 1 data address (ALUOut)
reg_write  output  1  RegisterBlock write enable (rw)
reg_dst  output  1  0 write Rt, 1 write Rd
mem_to_reg  output  1  0 ALUOut, 1 memory data
alu_src_a  output  1  0 PC, 1 Rs data
alu_src_b  output  2  00 Rt data, 01 const 1, 10 sign-ext imm, 11 sign-ext imm (branch offset)
alu_op  output  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT
state  output  3  current state code
illegal  output  1  sticky: unsupported opcode/funct seen
bus_error  output  1  sticky: mem_ready timeout

Behaviour:
- State register updates on rising clk. Codes: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7. Outputs decode combinationally from state, opcode, funct, alu_zero and mem_ready.
- Reset (sync, high): state<=FETCH, wait counter<=0, illegal<=0, bus_error<=0. While reset=1, all control outputs are forced 0 and state reads 0. Reset has priority over every transition, including mid-MEM.
- Supported opcodes: R-type 000000 (funct ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010), LW 100011, SW 101011, ADDI 001000, BEQ 000100, J 000010.
- FETCH: mem_read=1, iord=0. When mem_ready=1: ir_write=1, pc_write=1, pc_src=00, go to DECODE. Otherwise hold.
- DECODE (1 cycle): alu_src_a=0, alu_src_b=11, alu_op=ADD to precompute branch target, then go to EXEC. An unsupported opcode, or R-type with an unsupported funct, sets illegal and goes to FETCH (NOP).
- EXEC:
  - R-type: alu_src_a=1, alu_src_b=00, alu_op from funct, go to WB.
  - LW/SW/ADDI: alu_src_a=1, alu_src_b=10, ADD. LW/SW go to MEM; ADDI goes to WB.
  - BEQ: alu_src_a=1, alu_src_b=00, SUB. pc_write=alu_zero, pc_src=01, go to FETCH.
  - J: pc_write=1, pc_src=10, go to FETCH.
- MEM: iord=1. LW asserts mem_read; SW asserts mem_write. Hold until mem_ready=1, then LW goes to WB and SW goes to FETCH. Request signals stay asserted, and stable, for the whole wait.
- WB: reg_write=1. R-type: reg_dst=1, mem_to_reg=0. LW: reg_dst=0, mem_to_reg=1. ADDI: reg_dst=0, mem_to_reg=0. Go to FETCH.
- Latency with mem_ready tied high: R-type/ADDI 4 cycles, LW 5, SW 4, BEQ/J 3.
- Wait counter: increments each cycle in FETCH or MEM with mem_ready=0, and clears on any state change. On reaching MEM_WAIT_MAX: set bus_error, go to HALT, deassert requests.
- HALT: all control outputs 0; exit only by reset.
- mem_ready outside FETCH/MEM is ignored. alu_zero is used only in EXEC for BEQ.

Optional Feature:
HALT_ON_ILLEGAL_EN
- Defined: an illegal opcode/funct in DECODE sets illegal and goes to HALT. Exit only by reset.
- Undefined: sets illegal and returns to FETCH as a NOP. The PC is already advanced, so execution continues at the next instruction.

Test Plan:
- Reset held 2 cycles, then released with mem_ready=1 -> state=0, all outputs 0 during reset; first cycle after release shows mem_read=1, ir_write=1, pc_write=1.
- R-type ADD (opcode 000000, funct 100000), mem_ready=1 -> states 0,1,2,4,0; alu_op=0010 in EXEC; reg_write=1, reg_dst=1 in WB; 4 cycles total.
- LW, mem_ready low for 3 MEM cycles -> MEM held 4 cycles with mem_read=1, iord=1; then WB with mem_to_reg=1, reg_dst=0; bus_error stays 0.
- BEQ with alu_zero=1, then with alu_zero=0 -> EXEC pc_write=1, pc_src=01 in the first case; pc_write=0 in the second; both return to FETCH after 3 cycles.
- mem_ready held 0 in FETCH for MEM_WAIT_MAX=16 cycles -> bus_error=1, state=7, all requests 0; reset clears both.
- Opcode 111111 -> illegal=1. Without HALT_ON_ILLEGAL_EN, state returns to 0 next cycle. With HALT_ON_ILLEGAL_EN, state=7 until reset.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback.
// Define HALT_ON_ILLEGAL_EN to stop in HALT on an unsupported instruction.
//
//   state  | meaning
//   FETCH  | read instruction at PC, load IR and PC+1 on mem_ready
//   DECODE | precompute branch target, check opcode/funct
//   EXEC   | ALU operation, branch/jump resolution
//   MEM    | data load/store, hold until mem_ready
//   WB     | register file write
//   HALT   | bus timeout (or illegal instruction), exit only by reset
module mips_multicycle_ctrl #(
  parameter int MEM_WAIT_MAX = 16,
  parameter int WAIT_W       = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_op,
  output logic [2:0] state,
  output logic       illegal,
  output logic       bus_error
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                illegal_q, illegal_d;
  logic                bus_error_q, bus_error_d;

  logic       is_r, is_lw, is_sw, is_addi, is_beq, is_j;
  logic       funct_ok, instr_ok, wait_expired;
  logic [3:0] r_alu_op;

  assign is_r    = (opcode == OP_R);
  assign is_lw   = (opcode == OP_LW);
  assign is_sw   = (opcode == OP_SW);
  assign is_addi = (opcode == OP_ADDI);
  assign is_beq  = (opcode == OP_BEQ);
  assign is_j    = (opcode == OP_J);

  always_comb begin
    r_alu_op = ALU_AND;
    funct_ok = 1'b1;
    case (funct)
      6'b100000: r_alu_op = ALU_ADD;
      6'b100010: r_alu_op = ALU_SUB;
      6'b100100: r_alu_op = ALU_AND;
      6'b100101: r_alu_op = ALU_OR;
      6'b101010: r_alu_op = ALU_SLT;
      default:   funct_ok = 1'b0;
    endcase
  end

  assign instr_ok     = is_r ? funct_ok : (is_lw | is_sw | is_addi | is_beq | is_j);
  assign wait_expired = (wait_q == WAIT_W'(MEM_WAIT_MAX - 1));

  always_comb begin
    state_d     = state_q;
    illegal_d   = illegal_q;
    bus_error_d = bus_error_q;
    pc_write    = 1'b0;
    pc_src      = 2'b00;
    ir_write    = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    iord        = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = ALU_AND;

    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (wait_expired) begin
          bus_error_d = 1'b1;
          state_d     = S_HALT;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = ALU_ADD;
        if (instr_ok) begin
          state_d = S_EXEC;
        end else begin
          illegal_d = 1'b1;
`ifdef HALT_ON_ILLEGAL_EN
          state_d   = S_HALT;
`else
          state_d   = S_FETCH;
`endif
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        if (is_r) begin
          alu_src_a = 1'b1;
          alu_op    = r_alu_op;
          state_d   = S_WB;
        end else if (is_lw || is_sw || is_addi) begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = ALU_ADD;
          state_d   = is_addi ? S_WB : S_MEM;
        end else if (is_beq) begin
          alu_src_a = 1'b1;
          alu_op    = ALU_SUB;
          pc_write  = alu_zero;
          pc_src    = 2'b01;
        end else if (is_j) begin
          pc_write  = 1'b1;
          pc_src    = 2'b10;
        end
      end
      S_MEM: begin
        iord      = 1'b1;
        mem_read  = is_lw;
        mem_write = is_sw;
        if (mem_ready) begin
          state_d = is_lw ? S_WB : S_FETCH;
        end else if (wait_expired) begin
          bus_error_d = 1'b1;
          state_d     = S_HALT;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = is_r;
        mem_to_reg = is_lw;
        state_d    = S_FETCH;
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase

    // Reset blanks every control strobe immediately, not just from the next edge.
    if (reset) begin
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = ALU_AND;
    end
  end

  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      wait_q      <= '0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      illegal_q   <= illegal_d;
      bus_error_q <= bus_error_d;
    end
  end

  assign state     = reset ? 3'd0 : state_q;
  assign illegal   = illegal_q & ~reset;
  assign bus_error = bus_error_q & ~reset;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: stimulus pushes per-cycle expected
// control vectors, a negedge monitor pops and compares them.
module tb_mips_multicycle_ctrl;

  logic       clk;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       alu_zero, mem_ready;
  logic       pc_write, ir_write, mem_read, mem_write, iord;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a, illegal, bus_error;
  logic [1:0] pc_src, alu_src_b;
  logic [3:0] alu_op;
  logic [2:0] state;

  mips_multicycle_ctrl #(.MEM_WAIT_MAX(16), .WAIT_W(5)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .state(state), .illegal(illegal), .bus_error(bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {state, pc_write, pc_src, ir_write, mem_read, mem_write, iord,
  //  reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal, bus_error}
  logic [21:0] act;
  assign act = {state, pc_write, pc_src, ir_write, mem_read, mem_write, iord,
                reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                illegal, bus_error};

  typedef struct {
    logic [21:0] exp;
    string       name;
  } sb_t;

  sb_t sb[$];
  sb_t m_e;
  int  n_checks = 0;
  int  n_pass   = 0;

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] ADDI = 6'b001000, BEQ = 6'b000100, JMP = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [21:0] ILL = 22'b10, BE = 22'b01;

  function automatic logic [21:0] v(input logic [2:0] st, input logic pcw,
                                    input logic [1:0] pcs, input logic irw, mr, mw, io,
                                    input logic rw, rd, m2r, asa, input logic [1:0] asb,
                                    input logic [3:0] aop);
    return {st, pcw, pcs, irw, mr, mw, io, rw, rd, m2r, asa, asb, aop, 2'b00};
  endfunction

  task automatic cyc(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic rdy, input logic [21:0] e, input string nm);
    @(posedge clk);
    #1;
    reset = rst; opcode = op; funct = fn; alu_zero = z; mem_ready = rdy;
    sb.push_back('{exp: e, name: nm});
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        m_e = sb.pop_front();
        n_checks++;
        if (act === m_e.exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", m_e.name, act, m_e.exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [21:0] Z, F1, F0, DE, EM, EBQ1, EBQ0, EJ, MLW, MSW, WBR, WBL, WBI, H;
  logic [5:0]  r_fn  [4];
  logic [3:0]  r_aop [4];

  initial begin
    Z    = '0;
    F1   = v(3'd0, 1, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0000);
    F0   = v(3'd0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0000);
    DE   = v(3'd1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 4'b0010);
    EM   = v(3'd2, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 4'b0010);
    EBQ1 = v(3'd2, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'b0110);
    EBQ0 = v(3'd2, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'b0110);
    EJ   = v(3'd2, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0000);
    MLW  = v(3'd3, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 4'b0000);
    MSW  = v(3'd3, 0, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 4'b0000);
    WBR  = v(3'd4, 0, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 4'b0000);
    WBL  = v(3'd4, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 4'b0000);
    WBI  = v(3'd4, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 4'b0000);
    H    = v(3'd7, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0000);
    r_fn[0] = 6'b100010; r_aop[0] = 4'b0110;
    r_fn[1] = 6'b100100; r_aop[1] = 4'b0000;
    r_fn[2] = 6'b100101; r_aop[2] = 4'b0001;
    r_fn[3] = 6'b101010; r_aop[3] = 4'b0111;

    reset = 1'b1; opcode = R; funct = F_ADD; alu_zero = 1'b0; mem_ready = 1'b1;

    cyc(1, R, F_ADD, 0, 1, Z, "reset0");
    cyc(1, R, F_ADD, 1, 1, Z, "reset1");

    cyc(0, R, F_ADD, 0, 1, F1,  "add_fetch");
    cyc(0, R, F_ADD, 0, 1, DE,  "add_decode");
    cyc(0, R, F_ADD, 0, 1, v(3'd2, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'b0010), "add_exec");
    cyc(0, R, F_ADD, 0, 0, WBR, "add_wb");

    for (int i = 0; i < 4; i++) begin
      cyc(0, R, r_fn[i], 0, 1, F1, "rtype_fetch");
      cyc(0, R, r_fn[i], 0, 1, DE, "rtype_decode");
      cyc(0, R, r_fn[i], 0, 1,
          v(3'd2, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, r_aop[i]), "rtype_exec");
      cyc(0, R, r_fn[i], 0, 1, WBR, "rtype_wb");
    end

    cyc(0, LW, 6'd0, 0, 1, F1,  "lw_fetch");
    cyc(0, LW, 6'd0, 0, 0, DE,  "lw_decode");
    cyc(0, LW, 6'd0, 0, 0, EM,  "lw_exec");
    cyc(0, LW, 6'd0, 0, 0, MLW, "lw_mem_wait1");
    cyc(0, LW, 6'd0, 0, 0, MLW, "lw_mem_wait2");
    cyc(0, LW, 6'd0, 0, 0, MLW, "lw_mem_wait3");
    cyc(0, LW, 6'd0, 0, 1, MLW, "lw_mem_done");
    cyc(0, LW, 6'd0, 0, 1, WBL, "lw_wb");

    cyc(0, SW, 6'd0, 0, 1, F1,  "sw_fetch");
    cyc(0, SW, 6'd0, 0, 1, DE,  "sw_decode");
    cyc(0, SW, 6'd0, 0, 1, EM,  "sw_exec");
    cyc(0, SW, 6'd0, 0, 1, MSW, "sw_mem");

    cyc(0, ADDI, 6'd0, 0, 1, F1,  "addi_fetch");
    cyc(0, ADDI, 6'd0, 0, 1, DE,  "addi_decode");
    cyc(0, ADDI, 6'd0, 0, 1, EM,  "addi_exec");
    cyc(0, ADDI, 6'd0, 0, 1, WBI, "addi_wb");

    cyc(0, BEQ, 6'd0, 0, 1, F1,   "beq1_fetch");
    cyc(0, BEQ, 6'd0, 0, 1, DE,   "beq1_decode");
    cyc(0, BEQ, 6'd0, 1, 1, EBQ1, "beq1_exec_taken");
    cyc(0, BEQ, 6'd0, 1, 1, F1,   "beq0_fetch");
    cyc(0, BEQ, 6'd0, 1, 1, DE,   "beq0_decode_zero_ignored");
    cyc(0, BEQ, 6'd0, 0, 1, EBQ0, "beq0_exec_not_taken");

    cyc(0, JMP, 6'd0, 0, 1, F1, "j_fetch");
    cyc(0, JMP, 6'd0, 0, 1, DE, "j_decode");
    cyc(0, JMP, 6'd0, 0, 1, EJ, "j_exec");

    cyc(0, R, F_ADD, 0, 0, F0, "fetch_wait1");
    cyc(0, R, F_ADD, 0, 0, F0, "fetch_wait2");
    cyc(0, R, F_ADD, 0, 1, F1, "fetch_ready");
    cyc(0, R, F_ADD, 0, 1, DE, "fetch_wait_decode");
    cyc(0, R, F_ADD, 0, 1, v(3'd2, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'b0010), "fw_exec");
    cyc(0, R, F_ADD, 0, 1, WBR, "fw_wb");

    cyc(0, LW, 6'd0, 0, 1, F1,  "midmem_fetch");
    cyc(0, LW, 6'd0, 0, 1, DE,  "midmem_decode");
    cyc(0, LW, 6'd0, 0, 1, EM,  "midmem_exec");
    cyc(0, LW, 6'd0, 0, 0, MLW, "midmem_wait");
    cyc(1, LW, 6'd0, 0, 1, Z,   "midmem_reset");
    cyc(0, LW, 6'd0, 0, 1, F1,  "midmem_refetch");

    cyc(0, 6'b111111, 6'd0, 0, 1, DE, "illop_decode");
`ifdef HALT_ON_ILLEGAL_EN
    cyc(0, 6'b111111, 6'd0, 0, 1, H | ILL, "illop_halt1");
    cyc(0, R, F_ADD, 0, 1, H | ILL, "illop_halt2");
`else
    cyc(0, 6'b111111, 6'd0, 0, 1, F1 | ILL, "illop_nop_fetch");
    cyc(0, R, 6'b000000, 0, 1, DE | ILL, "illfn_decode");
    cyc(0, R, 6'b000000, 0, 1, F1 | ILL, "illfn_nop_fetch");
`endif
    cyc(1, R, F_ADD, 0, 1, Z, "ill_reset");

    for (int i = 0; i < 16; i++) cyc(0, R, F_ADD, 0, 0, F0, "timeout_wait");
    cyc(0, R, F_ADD, 0, 0, H | BE, "timeout_halt");
    cyc(0, R, F_ADD, 0, 1, H | BE, "timeout_halt_hold");
    cyc(1, R, F_ADD, 0, 1, Z, "timeout_reset");
    cyc(0, R, F_ADD, 0, 0, F0, "timeout_cleared");

    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending entries, required 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
